// File: rtl/spell_commit_pkg.sv
// Shared encodings for the spell commit stage: memory write types, commit
// FSM states and the registered memory request bundle.
package spell_commit_pkg;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_CODE = 2'd1;
  localparam logic [1:0] MEM_DATA = 2'd2;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_MEM_WAIT = 3'd1;
  localparam logic [2:0] ST_DELAY    = 3'd2;
  localparam logic [2:0] ST_SLEEP    = 3'd3;
  localparam logic [2:0] ST_STOPPED  = 3'd4;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_req_t;

  // A write count of 3 behaves exactly like 2.
  function automatic logic [1:0] eff_count(input logic [1:0] cnt);
    return (cnt == 2'd3) ? 2'd2 : cnt;
  endfunction

endpackage

// File: rtl/spell_stack.sv
// 32x8 data stack register file: synchronous reset, two combinational read
// ports at sp-1 / sp-2 and two write ports at wr_sp-1 / wr_sp-2. The write
// indices always differ, so the two ports never collide. All index math
// wraps modulo the depth.
module spell_stack
  import spell_commit_pkg::*;
#(
  parameter int STACK_DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] i_rd_sp,
  input  logic [4:0] i_wr_sp,
  input  logic       i_we_top,
  input  logic       i_we_below,
  input  logic [7:0] i_wd_top,
  input  logic [7:0] i_wd_below,
  output logic [7:0] o_top,
  output logic [7:0] o_below
);

  logic [7:0] r_mem [STACK_DEPTH];
  logic [4:0] w_rd_top;
  logic [4:0] w_rd_below;
  logic [4:0] w_wr_top;
  logic [4:0] w_wr_below;

  assign w_rd_top   = i_rd_sp - 5'd1;
  assign w_rd_below = i_rd_sp - 5'd2;
  assign w_wr_top   = i_wr_sp - 5'd1;
  assign w_wr_below = i_wr_sp - 5'd2;

  assign o_top   = r_mem[w_rd_top];
  assign o_below = r_mem[w_rd_below];

  // Clear every entry on reset, otherwise apply up to two writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (i_we_top) begin
        r_mem[w_wr_top] <= i_wd_top;
      end
      if (i_we_below) begin
        r_mem[w_wr_below] <= i_wd_below;
      end
    end
  end

endmodule

// File: rtl/spell_commit.sv
// Commit stage behind spell_execute. Owns PC, SP and the data stack, issues
// memory writes over a req/ack port, and sequences delay, sleep and stop.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  RUN       | accepting one execute result per cycle
//  MEM_WAIT  | memory write pending; req rises one cycle in, ends on ack
//  DELAY     | counting down delay_amount*DELAY_SCALE cycles
//  SLEEP     | idle until wake
//  STOPPED   | terminal until reset
module spell_commit
  import spell_commit_pkg::*;
#(
  parameter int STACK_DEPTH = 32,
  parameter int DELAY_SCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] next_pc,
  input  logic [4:0] next_sp,
  input  logic [1:0] stack_write_count,
  input  logic [7:0] set_stack_top,
  input  logic [7:0] set_stack_belowtop,
  input  logic [1:0] memory_write_type,
  input  logic [7:0] memory_write_addr,
  input  logic [7:0] memory_write_data,
  input  logic [7:0] delay_amount,
  input  logic       sleep,
  input  logic       stop,
  output logic [7:0] pc,
  output logic [4:0] sp,
  output logic [7:0] stack_top,
  output logic [7:0] stack_belowtop,
  output logic       mem_req,
  output logic [1:0] mem_type,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic       wake,
  output logic       sleeping,
  output logic       stopped
);

  localparam int SCALE_LOG = $clog2(DELAY_SCALE);
  localparam int CW        = 8 + SCALE_LOG;

  logic [2:0]    r_state;
  logic [7:0]    r_pc;
  logic [4:0]    r_sp;
  logic          r_mem_req;
  mem_req_t      r_mem;
  logic [CW-1:0] r_dly;

  logic          w_accept;
  logic [1:0]    w_cnt;
  logic [CW-1:0] w_dly_load;

  assign w_accept   = in_valid && (r_state == ST_RUN);
  assign w_cnt      = eff_count(stack_write_count);
  assign w_dly_load = CW'(delay_amount) << SCALE_LOG;

  assign in_ready  = (r_state == ST_RUN);
  assign sleeping  = (r_state == ST_SLEEP);
  assign stopped   = (r_state == ST_STOPPED);
  assign pc        = r_pc;
  assign sp        = r_sp;
  assign mem_req   = r_mem_req;
  assign mem_type  = r_mem.typ;
  assign mem_addr  = r_mem.addr;
  assign mem_wdata = r_mem.data;

  spell_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .reset      (reset),
    .i_rd_sp    (r_sp),
    .i_wr_sp    (next_sp),
    .i_we_top   (w_accept && (w_cnt != 2'd0)),
    .i_we_below (w_accept && (w_cnt == 2'd2)),
    .i_wd_top   (set_stack_top),
    .i_wd_below (set_stack_belowtop),
    .o_top      (stack_top),
    .o_below    (stack_belowtop)
  );

  // Commit FSM: architectural PC/SP, post-accept sequencing, memory request
  // and delay counter. Only one post-accept action is taken, stop first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= 8'h00;
      r_sp      <= 5'd0;
      r_mem_req <= 1'b0;
      r_mem     <= '{typ: MEM_NONE, addr: 8'h00, data: 8'h00};
      r_dly     <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (in_valid) begin
            r_pc <= next_pc;
            r_sp <= next_sp;
            if (stop) begin
              r_state <= ST_STOPPED;
            end else if (memory_write_type != MEM_NONE) begin
              r_state <= ST_MEM_WAIT;
              r_mem   <= '{typ: memory_write_type, addr: memory_write_addr,
                           data: memory_write_data};
            end else if (delay_amount != 8'h00) begin
              r_state <= ST_DELAY;
              r_dly   <= w_dly_load;
            end else if (sleep) begin
              r_state <= ST_SLEEP;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_RUN;
          end
        end
        ST_DELAY: begin
          if (r_dly == CW'(1)) begin
            r_state <= ST_RUN;
          end else begin
            r_dly <= r_dly - CW'(1);
          end
        end
        ST_SLEEP: begin
          if (wake) begin
            r_state <= ST_RUN;
          end
        end
        ST_STOPPED: begin
          r_state <= ST_STOPPED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spell_commit.sv
// Scoreboard bench for spell_commit: stimulus pushes expected commit results
// and memory transactions; a monitor pops and compares them as the DUT
// accepts inputs and completes memory handshakes.
module tb_spell_commit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] next_pc;
  logic [4:0] next_sp;
  logic [1:0] stack_write_count;
  logic [7:0] set_stack_top;
  logic [7:0] set_stack_belowtop;
  logic [1:0] memory_write_type;
  logic [7:0] memory_write_addr;
  logic [7:0] memory_write_data;
  logic [7:0] delay_amount;
  logic       sleep;
  logic       stop;
  logic [7:0] pc;
  logic [4:0] sp;
  logic [7:0] stack_top;
  logic [7:0] stack_belowtop;
  logic       mem_req;
  logic [1:0] mem_type;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic       wake;
  logic       sleeping;
  logic       stopped;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] pc;
    logic [4:0] sp;
    logic [7:0] top;
    logic [7:0] below;
  } acc_exp_t;

  typedef struct {
    logic [1:0] typ;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_exp_t;

  acc_exp_t q_acc[$];
  mem_exp_t q_mem[$];

  spell_commit #(.STACK_DEPTH(32), .DELAY_SCALE(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .next_pc            (next_pc),
    .next_sp            (next_sp),
    .stack_write_count  (stack_write_count),
    .set_stack_top      (set_stack_top),
    .set_stack_belowtop (set_stack_belowtop),
    .memory_write_type  (memory_write_type),
    .memory_write_addr  (memory_write_addr),
    .memory_write_data  (memory_write_data),
    .delay_amount       (delay_amount),
    .sleep              (sleep),
    .stop               (stop),
    .pc                 (pc),
    .sp                 (sp),
    .stack_top          (stack_top),
    .stack_belowtop     (stack_belowtop),
    .mem_req            (mem_req),
    .mem_type           (mem_type),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .wake               (wake),
    .sleeping           (sleeping),
    .stopped            (stopped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clr_inputs();
    in_valid           = 1'b0;
    next_pc            = 8'h00;
    next_sp            = 5'd0;
    stack_write_count  = 2'd0;
    set_stack_top      = 8'h00;
    set_stack_belowtop = 8'h00;
    memory_write_type  = 2'd0;
    memory_write_addr  = 8'h00;
    memory_write_data  = 8'h00;
    delay_amount       = 8'h00;
    sleep              = 1'b0;
    stop               = 1'b0;
  endtask

  // Drive one execute result for a single cycle and queue the expected
  // architectural view after it commits. Returns just after the accept edge.
  task automatic issue(input logic [7:0] npc, input logic [4:0] nsp,
                       input logic [1:0] cnt, input logic [7:0] top,
                       input logic [7:0] below, input logic [1:0] mtyp,
                       input logic [7:0] maddr, input logic [7:0] mdata,
                       input logic [7:0] dly, input logic slp, input logic stp,
                       input logic [7:0] exp_top, input logic [7:0] exp_below);
    acc_exp_t e;
    @(negedge clk);
    chk("ready_before_issue", int'(in_ready), 1);
    in_valid           = 1'b1;
    next_pc            = npc;
    next_sp            = nsp;
    stack_write_count  = cnt;
    set_stack_top      = top;
    set_stack_belowtop = below;
    memory_write_type  = mtyp;
    memory_write_addr  = maddr;
    memory_write_data  = mdata;
    delay_amount       = dly;
    sleep              = slp;
    stop               = stp;
    e.pc = npc; e.sp = nsp; e.top = exp_top; e.below = exp_below;
    q_acc.push_back(e);
    @(posedge clk);
    #1;
    clr_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares committed state after each accept edge and the
  // memory request fields on each req/ack handshake edge.
  always @(posedge clk) begin
    logic     acc;
    logic     hs;
    mem_exp_t got_m;
    acc = in_valid && in_ready && !reset;
    hs  = mem_req && mem_ack && !reset;
    got_m.typ = mem_type; got_m.addr = mem_addr; got_m.data = mem_wdata;
    if (hs) begin
      if (q_mem.size() == 0) begin
        chk("mem_unexpected", 1, 0);
      end else begin
        mem_exp_t em;
        em = q_mem.pop_front();
        chk("mem_type", int'(got_m.typ), int'(em.typ));
        chk("mem_addr", int'(got_m.addr), int'(em.addr));
        chk("mem_wdata", int'(got_m.data), int'(em.data));
      end
    end
    #1;
    if (acc) begin
      if (q_acc.size() == 0) begin
        chk("acc_unexpected", 1, 0);
      end else begin
        acc_exp_t ea;
        ea = q_acc.pop_front();
        chk("commit_pc", int'(pc), int'(ea.pc));
        chk("commit_sp", int'(sp), int'(ea.sp));
        chk("commit_top", int'(stack_top), int'(ea.top));
        chk("commit_below", int'(stack_belowtop), int'(ea.below));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    int rq;
    int sc;
    int ok;
    mem_exp_t m;

    reset   = 1'b1;
    mem_ack = 1'b0;
    wake    = 1'b0;
    clr_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_sp", int'(sp), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_type", int'(mem_type), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_sleeping", int'(sleeping), 0);
    chk("rst_stopped", int'(stopped), 0);
    chk("rst_top", int'(stack_top), 0);

    // push 0x41, push 0x42, add -> 0x83 at sp=1
    issue(8'd1, 5'd1, 2'd1, 8'h41, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h41, 8'h00);
    issue(8'd2, 5'd2, 2'd1, 8'h42, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h42, 8'h41);
    issue(8'd3, 5'd1, 2'd1, 8'h83, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h83, 8'h00);
    chk("add_ready", int'(in_ready), 1);
    // two-entry write, then count 3 behaving as 2
    issue(8'd4, 5'd3, 2'd2, 8'h11, 8'h22, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h11, 8'h22);
    issue(8'd5, 5'd3, 2'd3, 8'h33, 8'h44, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h33, 8'h44);

    // wrap: fill slots 30/29 landing at sp=31, push wraps to 0, pop back to 31
    issue(8'd6, 5'd31, 2'd2, 8'h66, 8'h77, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h66, 8'h77);
    issue(8'd7, 5'd0, 2'd1, 8'h55, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h55, 8'h66);
    issue(8'd8, 5'd31, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h66, 8'h77);
    issue(8'd9, 5'd0, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h55, 8'h66);
    issue(8'd10, 5'd1, 2'd1, 8'h99, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 8'h99, 8'h55);

    // data write, ack on 3rd req cycle; an early ack while req=0 is ignored
    m.typ = 2'd2; m.addr = 8'h10; m.data = 8'hAA;
    q_mem.push_back(m);
    issue(8'd11, 5'd1, 2'd0, 8'h00, 8'h00, 2'd2, 8'h10, 8'hAA, 8'd0, 1'b0, 1'b0, 8'h99, 8'h55);
    nr = 0; rq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        mem_ack = 1'b0;
        break;
      end
      nr++;
      if (mem_req) begin
        rq++;
        chk("mem_addr_stable", int'(mem_addr), 'h10);
        chk("mem_data_stable", int'(mem_wdata), 'hAA);
      end
      mem_ack = (mem_req && rq == 3) || !mem_req;
    end
    mem_ack = 1'b0;
    chk("mem_req_cycles", rq, 3);
    chk("mem_notready_cycles", nr, 4);

    // delay 5, with wake held high to show it is ignored outside SLEEP
    wake = 1'b1;
    issue(8'd12, 5'd1, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd5, 1'b0, 1'b0, 8'h99, 8'h55);
    nr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) break;
      nr++;
    end
    wake = 1'b0;
    chk("delay5_cycles", nr, 5);
    issue(8'd13, 5'd1, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd1, 1'b0, 1'b0, 8'h99, 8'h55);
    nr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) break;
      nr++;
    end
    chk("delay1_cycles", nr, 1);

    // sleep, wake pulsed in the 7th sleeping cycle
    issue(8'd14, 5'd1, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b1, 1'b0, 8'h99, 8'h55);
    sc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (sleeping) sc++;
      wake = (sc == 7);
    end
    wake = 1'b0;
    chk("sleep_cycles", sc, 7);
    chk("sleep_exit_sleeping", int'(sleeping), 0);

    // stop with a memory write also requested: stop wins, no request appears
    issue(8'd15, 5'd2, 2'd1, 8'hC3, 8'h00, 2'd2, 8'h40, 8'h01, 8'd0, 1'b0, 1'b1, 8'hC3, 8'h99);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      next_pc  = 8'h77;
      mem_ack  = 1'b1;
      if (stopped && !in_ready && !mem_req && pc == 8'd15) ok++;
    end
    clr_inputs();
    mem_ack = 1'b0;
    chk("stopped_cycles", ok, 100);
    do_reset();
    @(negedge clk);
    chk("stop_rst_pc", int'(pc), 0);
    chk("stop_rst_sp", int'(sp), 0);
    chk("stop_rst_stopped", int'(stopped), 0);
    chk("stop_rst_ready", int'(in_ready), 1);

    // reset in the middle of MEM_WAIT
    issue(8'd1, 5'd1, 2'd1, 8'h01, 8'h00, 2'd1, 8'h20, 8'h5A, 8'd0, 1'b0, 1'b0, 8'h01, 8'h00);
    repeat (2) @(negedge clk);
    chk("midwait_req", int'(mem_req), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midwait_rst_req", int'(mem_req), 0);
    chk("midwait_rst_ready", int'(in_ready), 1);
    chk("midwait_rst_type", int'(mem_type), 0);
    @(negedge clk);
    reset   = 1'b0;
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_req", int'(mem_req), 0);
    chk("late_ack_pc", int'(pc), 0);
    chk("late_ack_ready", int'(in_ready), 1);

    repeat (2) @(negedge clk);
    chk("acc_queue_empty", q_acc.size(), 0);
    chk("mem_queue_empty", q_mem.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
